// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_pkg
// Brief    : Shared UART transmit state encodings, line levels and defaults.
// Revision : 1.0
// ============================================================================
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic c_UART_IDLE_LVL = 1'b1;
    localparam int   c_DEF_DATA_W    = 8;
    localparam int   c_DEF_CLK_DIV   = 5000;

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : 8N1 frame serializer with bit-timing counter, LSB-first payload.
// Revision : 1.0
// ============================================================================
module uart_tx_frame
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int CLK_DIV = c_DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_byte,
    output logic              o_tx,
    output logic              o_done
);

    localparam int c_CNT_W = $clog2(CLK_DIV);
    localparam int c_IDX_W = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);

    tx_state_t           r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [c_IDX_W-1:0]  r_idx,   w_idx_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic                r_tx,    w_tx_nxt;
    logic                w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= c_UART_IDLE_LVL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // tx is registered: each state transition also loads the level for the next slot
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_shift_nxt = i_byte;
                    w_tx_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_IDX_LAST) begin
                        w_tx_nxt    = c_UART_IDLE_LVL;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_tx   = r_tx;
    assign o_done = w_done;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one UART TX line among N_REQ byte producers.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int CLK_DIV = c_DEF_CLK_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          ack,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      tx
);

    localparam int c_ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  r_ack;
    logic [c_ID_W-1:0] r_grant;
    logic [c_ID_W-1:0] r_rr;
    logic              r_busy;

    logic              w_found;
    logic [c_ID_W-1:0] w_win;
    logic [c_ID_W-1:0] w_idx;
    int                w_j;
    logic              w_load;
    logic [DATA_W-1:0] w_byte;
    logic              w_done;

    // First requester at or after the rr pointer, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = 0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = int'(r_rr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            w_idx = c_ID_W'(w_j);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_load = !r_busy && w_found;
    assign w_byte = data[w_win*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= '0;
            r_grant <= '0;
            r_rr    <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_load) begin
                r_ack[w_win] <= 1'b1;
                r_grant      <= w_win;
                r_busy       <= 1'b1;
                r_rr         <= (w_win == c_ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
            end else if (w_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    uart_tx_frame #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_byte (w_byte),
        .o_tx   (tx),
        .o_done (w_done)
    );

    assign ack      = r_ack;
    assign grant_id = r_grant;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter (CLK_DIV=4).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int DIV = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   ack;
    logic [1:0]     grant_id;
    logic           busy;
    logic           tx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [7:0] b;
        logic [9:0] seq;   // seq[9] is the first bit on the line
    } frame_vec_t;

    frame_vec_t tbl [5];

    uart_tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (W),
        .CLK_DIV (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] got, output int n);
        got = '0;
        n   = 0;
        while (n < budget && got == '0) begin
            step();
            n++;
            got = ack;
        end
    endtask

    task automatic run_frame(input int id, input logic [7:0] b, input logic [9:0] seq);
        req = '0;
        data[id*W +: W] = b;
        req[id] = 1'b1;
        step();
        chk("frame_ack", 32'(ack), 32'(1 << id));
        chk("frame_grant", 32'(grant_id), 32'(id));
        req = '0;
        for (int bit_i = 0; bit_i < 10; bit_i++) begin
            for (int k = 0; k < DIV; k++) begin
                if (bit_i != 0 || k != 0) begin
                    step();
                    chk("frame_ack_low", 32'(ack), 32'd0);
                end
                chk("frame_tx", 32'(tx), 32'(seq[9 - bit_i]));
                chk("frame_busy", 32'(busy), 32'd1);
            end
        end
        step();
        chk("gap_busy", 32'(busy), 32'd0);
        chk("gap_tx", 32'(tx), 32'd1);
    endtask

    initial begin
        logic [N-1:0] got;
        int           n;
        int           seen;

        tbl[0] = '{id: 0, b: 8'h61, seq: 10'b0_10000110_1};
        tbl[1] = '{id: 1, b: 8'hA5, seq: 10'b0_10100101_1};
        tbl[2] = '{id: 2, b: 8'h00, seq: 10'b0_00000000_1};
        tbl[3] = '{id: 3, b: 8'hFF, seq: 10'b0_11111111_1};
        tbl[4] = '{id: 2, b: 8'h3C, seq: 10'b0_00111100_1};

        rst  = 1'b1;
        req  = '0;
        data = '0;

        // Reset state held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_grant", 32'(grant_id), 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].id, tbl[i].b, tbl[i].seq);
        end

        // All four requesting from reset, each released on its own ack
        req  = '0;
        do_reset(2);
        rst  = 1'b1;
        data = 32'h44332211;
        req  = 4'hF;
        step();
        rst  = 1'b0;
        for (int f = 0; f < 4; f++) begin
            wait_ack(100, got, n);
            chk("all4_ack", 32'(got), 32'(1 << f));
            chk("all4_grant", 32'(grant_id), 32'(f));
            if (f > 0) chk("all4_gap", 32'(n), 32'd41);
            req[f] = 1'b0;
        end

        // req[0] and req[2] held continuously
        rst = 1'b1;
        req = 4'b0101;
        step();
        rst = 1'b0;
        for (int f = 0; f < 4; f++) begin
            wait_ack(100, got, n);
            chk("alt_ack", 32'(got), (f % 2 == 0) ? 32'h1 : 32'h4);
            chk("alt_grant", 32'(grant_id), (f % 2 == 0) ? 32'd0 : 32'd2);
            if (f > 0) chk("alt_gap", 32'(n), 32'd41);
        end

        // Reset in cycle 15 of a frame; req[1] held throughout
        req = '0;
        do_reset(2);
        data = '0;
        req  = 4'b0010;
        wait_ack(100, got, n);
        chk("mid_ack", 32'(got), 32'h2);
        chk("mid_latency", 32'(n), 32'd1);
        repeat (14) step();
        chk("mid_tx_before", 32'(tx), 32'd0);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_tx_reset", 32'(tx), 32'd1);
        chk("mid_busy_reset", 32'(busy), 32'd0);
        chk("mid_ack_reset", 32'(ack), 32'd0);
        rst = 1'b0;
        step();
        chk("mid_regrant_ack", 32'(ack), 32'h2);
        chk("mid_regrant_grant", 32'(grant_id), 32'd1);
        chk("mid_regrant_tx", 32'(tx), 32'd0);

        // req[3] withdrawn during another requester's frame
        req = '0;
        do_reset(2);
        data[0 +: W] = 8'h55;
        req = 4'b0001;
        wait_ack(100, got, n);
        chk("wd_ack0", 32'(got), 32'h1);
        req = '0;
        repeat (5) step();
        req[3] = 1'b1;
        repeat (10) step();
        req[3] = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ack != '0) seen++;
        end
        chk("wd_no_ack", 32'(seen), 32'd0);
        chk("wd_busy", 32'(busy), 32'd0);
        chk("wd_tx", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
